axi_lite_cpu_bridge: RTL and testbench
======================================

Name: axi_lite_cpu_bridge

Overview:
Upstream master stage for the SoC AXI-Lite fabric. It converts a PicoRV32-style native memory request (valid/ready, wstrb≠0 means write) into single, non-overlapping AXI-Lite transactions on the master port of the address-decoding interconnect. Write phases are strictly ordered AW → W → B, because the fabric routes W only after the AW handshake. Read address and arprot are held stable until the R handshake, because the fabric routes R by the current araddr.

Parameters:
ADDR_WIDTH, 32, width of mem_addr and AXI addresses
DATA_WIDTH, 32, data width; fixed at 32 (wstrb 4 bits)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
mem_valid  in  1  CPU request valid; held until mem_ready
mem_instr  in  1  request is an instruction fetch
mem_addr  in  ADDR_WIDTH  byte address
mem_wdata  in  32  write data
mem_wstrb  in  4  byte enables; 0 = read
mem_ready  out  1  one-cycle completion pulse
mem_rdata  out  32  read data, valid while mem_ready=1
mem_err  out  1  pulses with mem_ready if rresp≠OKAY
m_axi_awvalid  out  1  AW valid
m_axi_awready  in  1  AW ready
m_axi_awaddr  out  ADDR_WIDTH  write address
m_axi_awprot  out  3  always 3'b000
m_axi_wvalid  out  1  W valid
m_axi_wready  in  1  W ready
m_axi_wdata  out  32  write data
m_axi_wstrb  out  4  write strobes
m_axi_bvalid  in  1  B valid (no bresp on fabric)
m_axi_bready  out  1  B ready
m_axi_arvalid  out  1  AR valid
m_axi_arready  in  1  AR ready
m_axi_araddr  out  ADDR_WIDTH  read address
m_axi_arprot  out  3  {mem_instr,2'b00} latched
m_axi_rvalid  in  1  R valid
m_axi_rready  out  1  R ready
m_axi_rdata  in  32  read data
m_axi_rresp  in  2  read response

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE; all valid/ready outputs 0; mem_ready=0; mem_err=0; mem_rdata=0; address/data/prot registers 0. A reset mid-transaction abandons it immediately; no completion pulse is issued.
- FSM states: IDLE, AW, W, B, AR, R, DONE. All AXI valid/ready outputs are registered state decodes: awvalid=(AW), wvalid=(W), bready=(B), arvalid=(AR), rready=(R). mem_ready=(DONE).
- IDLE: if mem_valid=1, latch addr, wdata, wstrb and prot. Go to AW if wstrb≠0, else AR. mem_valid is not sampled in any state other than IDLE.
- AW: stay until awready; then W. AW and W are never asserted together.
- W: stay until wready; then B.
- B: stay until bvalid; then DONE.
- AR: stay until arready; then R.
- R: stay until rvalid. On rvalid, capture mem_rdata←rdata and err←(rresp≠2'b00), then go to DONE.
- DONE: assert mem_ready (and mem_err if the flag is set) for exactly 1 cycle, then go to IDLE. A mem_valid seen in the next cycle starts a new request.
- Writes: mem_rdata is unchanged and mem_err=0.
- Held stability: awaddr, wdata, wstrb, araddr and arprot stay constant from IDLE exit until the next IDLE exit. araddr must stay stable through the R state.
- Early responses: a slave asserting bvalid or rvalid early is tolerated, since the handshake completes when the FSM reaches B or R. Ready inputs seen outside their own state are ignored.
- Latency with a zero-wait slave, request sampled at cycle 0:
  - write: AW handshake at c1, W at c2, B at c3 (bvalid at c3), mem_ready at c4.
  - read: AR handshake at c1, R at c2, mem_ready at c3.
- Throughput: one outstanding transaction; no pipelining.

Test Plan:
- Write 0x1000_0004, wdata 0xA5A5_5A5A, wstrb 4'hF, zero-wait slave -> awvalid c1 with awaddr 0x1000_0004; wvalid c2 only (never overlaps awvalid) with wstrb F; bready c3; mem_ready c4.
- Read 0x0000_0010, mem_instr=1, slave returns 0x1234_5678 with OKAY after 3 wait cycles on arready and 2 on rvalid -> arprot=3'b100; araddr held through R; mem_rdata=0x1234_5678 on the single mem_ready pulse; mem_err=0.
- Read with rresp=2'b10 -> mem_ready pulse with mem_err=1 in the same cycle; next read with OKAY -> mem_err=0.
- Slave drives bvalid=1 before wready completes, and awready=1 while in W -> no spurious transitions; the sequence still completes exactly once.
- Back-to-back requests (read then write with mem_valid re-asserted the cycle after mem_ready) -> second transaction starts the next cycle; first-read data unaffected.
- resetn pulled low while in W -> wvalid and all outputs 0 asynchronously; after release, state=IDLE and no mem_ready is emitted for the aborted write.

Source files
------------

// File: rtl/axi_lite_cpu_bridge.sv
// axi_lite_cpu_bridge: turns a PicoRV32-style native memory request into a
// single AXI-Lite transaction. Writes run AW -> W -> B strictly in order;
// reads hold araddr/arprot until the R handshake so the fabric can route R.
module axi_lite_cpu_bridge #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      resetn,
   // CPU native memory port
   input  logic                      mem_valid,
   input  logic                      mem_instr,
   input  logic [ADDR_WIDTH-1:0]     mem_addr,
   input  logic [DATA_WIDTH-1:0]     mem_wdata,
   input  logic [DATA_WIDTH/8-1:0]   mem_wstrb,
   output logic                      mem_ready,
   output logic [DATA_WIDTH-1:0]     mem_rdata,
   output logic                      mem_err,
   // AXI-Lite master port
   output logic                      m_axi_awvalid,
   input  logic                      m_axi_awready,
   output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
   output logic [2:0]                m_axi_awprot,
   output logic                      m_axi_wvalid,
   input  logic                      m_axi_wready,
   output logic [DATA_WIDTH-1:0]     m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
   input  logic                      m_axi_bvalid,
   output logic                      m_axi_bready,
   output logic                      m_axi_arvalid,
   input  logic                      m_axi_arready,
   output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
   output logic [2:0]                m_axi_arprot,
   input  logic                      m_axi_rvalid,
   output logic                      m_axi_rready,
   input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
   input  logic [1:0]                m_axi_rresp
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_AW,
      S_W,
      S_B,
      S_AR,
      S_R,
      S_DONE
   } state_t;

   state_t                    state;
   state_t                    state_nx;
   logic [ADDR_WIDTH-1:0]     addr_q;
   logic [DATA_WIDTH-1:0]     wdata_q;
   logic [DATA_WIDTH/8-1:0]   wstrb_q;
   logic [2:0]                prot_q;

   // Request fields are latched once at IDLE exit and held for the whole transaction.
   assign m_axi_awaddr = addr_q;
   assign m_axi_araddr = addr_q;
   assign m_axi_awprot = 3'b000;
   assign m_axi_arprot = prot_q;
   assign m_axi_wdata  = wdata_q;
   assign m_axi_wstrb  = wstrb_q;

   // Next-state decode: each phase only advances on its own handshake input.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: if (mem_valid) state_nx = (mem_wstrb != '0) ? S_AW : S_AR;
         S_AW:   if (m_axi_awready) state_nx = S_W;
         S_W:    if (m_axi_wready)  state_nx = S_B;
         S_B:    if (m_axi_bvalid)  state_nx = S_DONE;
         S_AR:   if (m_axi_arready) state_nx = S_R;
         S_R:    if (m_axi_rvalid)  state_nx = S_DONE;
         S_DONE: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // State register; handshake outputs are registered decodes of the next state.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state         <= S_IDLE;
         m_axi_awvalid <= 1'b0;
         m_axi_wvalid  <= 1'b0;
         m_axi_bready  <= 1'b0;
         m_axi_arvalid <= 1'b0;
         m_axi_rready  <= 1'b0;
         mem_ready     <= 1'b0;
         mem_err       <= 1'b0;
         mem_rdata     <= '0;
         addr_q        <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         prot_q        <= '0;
      end else begin
         state         <= state_nx;
         m_axi_awvalid <= (state_nx == S_AW);
         m_axi_wvalid  <= (state_nx == S_W);
         m_axi_bready  <= (state_nx == S_B);
         m_axi_arvalid <= (state_nx == S_AR);
         m_axi_rready  <= (state_nx == S_R);
         mem_ready     <= (state_nx == S_DONE);
         // Only a read completion can raise the error flag; write completions clear it.
         mem_err       <= (state == S_R) && m_axi_rvalid && (m_axi_rresp != 2'b00);
         if (state == S_IDLE && mem_valid) begin
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            wstrb_q <= mem_wstrb;
            prot_q  <= {mem_instr, 2'b00};
         end
         if (state == S_R && m_axi_rvalid) begin
            mem_rdata <= m_axi_rdata;
         end
      end
   end

endmodule

// File: tb/tb_axi_lite_cpu_bridge.sv
// Bench for axi_lite_cpu_bridge: directed latency/corner cases plus random
// requests against a randomized slave, checked by a transaction-level model.
module tb_axi_lite_cpu_bridge;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        mem_valid = 1'b0;
   logic        mem_instr = 1'b0;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_wdata = '0;
   logic [3:0]  mem_wstrb = '0;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        mem_err;
   logic        awvalid, awready = 1'b0;
   logic [31:0] awaddr;
   logic [2:0]  awprot;
   logic        wvalid, wready = 1'b0;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        bvalid = 1'b0, bready;
   logic        arvalid, arready = 1'b0;
   logic [31:0] araddr;
   logic [2:0]  arprot;
   logic        rvalid = 1'b0, rready;
   logic [31:0] rdata = '0;
   logic [1:0]  rresp = '0;

   axi_lite_cpu_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk(clk), .resetn(resetn),
      .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
      .mem_rdata(mem_rdata), .mem_err(mem_err),
      .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr),
      .m_axi_awprot(awprot), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
      .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_bvalid(bvalid),
      .m_axi_bready(bready), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
      .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_rvalid(rvalid),
      .m_axi_rready(rready), .m_axi_rdata(rdata), .m_axi_rresp(rresp)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected transaction (driver-owned)
   logic        exp_write;
   logic [31:0] exp_addr, exp_wdata;
   logic [3:0]  exp_strb;
   logic [2:0]  exp_prot;
   logic        outstanding = 1'b0;
   int          t_issue;
   int          t_aw, t_w, t_b, t_ar, t_r, t_done;

   // Observations (compare-owned)
   int          aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic [31:0] r_data_seen;
   logic [1:0]  r_resp_seen;
   logic [31:0] last_read = '0;
   logic [31:0] done_rdata;
   logic        done_err;
   logic [2:0]  seen_arprot;
   int          done_cnt = 0;

   // Slave behaviour
   int          mode = 0;
   logic        w_block = 1'b0;
   logic [31:0] fix_rdata = '0;
   logic [1:0]  fix_rresp = '0;
   int          wcnt = 0, arcnt = 0, rcnt = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Slave: drives handshake inputs shortly after each rising edge
   initial forever begin
      @(posedge clk);
      #1;
      case (mode)
         0: begin
            awready = 1'($urandom_range(0, 1));
            wready  = 1'($urandom_range(0, 1));
            bvalid  = 1'($urandom_range(0, 1));
            arready = 1'($urandom_range(0, 1));
            rvalid  = 1'($urandom_range(0, 1));
            rdata   = $urandom;
            rresp   = 2'($urandom_range(0, 3));
         end
         1: begin
            awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
            arready = 1'b1; rvalid = 1'b1;
            rdata = fix_rdata; rresp = fix_rresp;
         end
         2: begin
            awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
            arready = arvalid && (arcnt >= 3);
            rvalid  = rready && (rcnt >= 2);
            arcnt   = arvalid ? arcnt + 1 : 0;
            rcnt    = rready ? rcnt + 1 : 0;
            rdata = fix_rdata; rresp = fix_rresp;
         end
         default: begin
            awready = 1'b1; bvalid = 1'b1; arready = 1'b1; rvalid = 1'b1;
            wready  = wvalid && (wcnt >= 3) && !w_block;
            wcnt    = wvalid ? wcnt + 1 : 0;
            rdata = fix_rdata; rresp = fix_rresp;
         end
      endcase
   end

   // Compare process: checks protocol and the expected transaction every cycle
   initial forever begin
      @(negedge clk);
      if (!resetn) begin
         aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
      end else begin
         chk("aw_w_overlap", 32'(awvalid & wvalid), 0);
         chk("awprot", 32'(awprot), 0);
         chk("err_without_ready", 32'(mem_err & ~mem_ready), 0);
         chk("activity_idle",
             32'(~outstanding & (awvalid | wvalid | bready | arvalid | rready | mem_ready)), 0);
         if (outstanding) begin
            if (awvalid && t_aw < 0) t_aw = cyc - t_issue;
            if (wvalid && t_w < 0) t_w = cyc - t_issue;
            if (bready && t_b < 0) t_b = cyc - t_issue;
            if (arvalid && t_ar < 0) t_ar = cyc - t_issue;
            if (rready && t_r < 0) t_r = cyc - t_issue;
            if (mem_ready && t_done < 0) t_done = cyc - t_issue;
         end
         if (awvalid) begin
            chk("aw_addr", awaddr, exp_addr);
            chk("aw_is_write", 32'(exp_write), 1);
            chk("aw_once", aw_hs, 0);
         end
         if (wvalid) begin
            chk("w_data", wdata, exp_wdata);
            chk("w_strb", 32'(wstrb), 32'(exp_strb));
            chk("w_after_aw", aw_hs, 1);
            chk("w_once", w_hs, 0);
         end
         if (bready) begin
            chk("b_after_w", w_hs, 1);
            chk("b_once", b_hs, 0);
         end
         if (arvalid) begin
            chk("ar_addr", araddr, exp_addr);
            chk("ar_prot", 32'(arprot), 32'(exp_prot));
            chk("ar_is_read", 32'(exp_write), 0);
            chk("ar_once", ar_hs, 0);
            seen_arprot = arprot;
         end
         if (rready) begin
            chk("r_addr_held", araddr, exp_addr);
            chk("r_prot_held", 32'(arprot), 32'(exp_prot));
            chk("r_after_ar", ar_hs, 1);
         end
         if (mem_ready) begin
            if (exp_write) begin
               chk("done_wr_handshakes", {aw_hs[3:0], w_hs[3:0], b_hs[3:0], ar_hs[3:0], r_hs[3:0]},
                   32'h11100);
               chk("done_wr_rdata", mem_rdata, last_read);
               chk("done_wr_err", 32'(mem_err), 0);
            end else begin
               chk("done_rd_handshakes", {aw_hs[3:0], w_hs[3:0], b_hs[3:0], ar_hs[3:0], r_hs[3:0]},
                   32'h00011);
               chk("done_rd_rdata", mem_rdata, r_data_seen);
               chk("done_rd_err", 32'(mem_err), 32'(r_resp_seen != 2'b00));
               last_read = r_data_seen;
            end
            done_rdata = mem_rdata;
            done_err   = mem_err;
            done_cnt++;
            outstanding = 1'b0;
            aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
         end
         if (awvalid && awready) aw_hs++;
         if (wvalid && wready) w_hs++;
         if (bready && bvalid) b_hs++;
         if (arvalid && arready) ar_hs++;
         if (rready && rvalid) begin
            r_hs++;
            r_data_seen = rdata;
            r_resp_seen = rresp;
         end
      end
   end

   // Present a request just after a rising edge
   task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic ins);
      exp_write = wr; exp_addr = a; exp_wdata = d; exp_strb = s;
      exp_prot = {ins, 2'b00};
      t_issue = cyc;
      t_aw = -1; t_w = -1; t_b = -1; t_ar = -1; t_r = -1; t_done = -1;
      outstanding = 1'b1;
      mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s; mem_instr = ins;
   endtask

   // Wait for the completion pulse; returns just after the edge that ends it
   task automatic wait_done(input string name);
      int n = 0;
      while (outstanding && n < 300) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk({name, "_timeout"}, 32'(outstanding), 0);
      outstanding = 1'b0;
   endtask

   task automatic idle();
      mem_valid = 1'b0; mem_wstrb = '0; mem_instr = 1'b0;
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_ctrl"}, 32'({awvalid, wvalid, bready, arvalid, rready, mem_ready, mem_err}), 0);
      chk({name, "_addr"}, awaddr | araddr, 0);
      chk({name, "_wdata"}, wdata, 0);
      chk({name, "_prot_strb"}, 32'({arprot, wstrb}), 0);
      chk({name, "_rdata"}, mem_rdata, 0);
   endtask

   initial begin
      int done_before;
      int n;
      logic wr;
      logic [3:0] s;

      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset_state");
      #1 resetn = 1'b1;
      @(posedge clk); #1;

      // Zero-wait write latency
      mode = 1;
      @(posedge clk); #1;
      issue(1'b1, 32'h1000_0004, 32'hA5A5_5A5A, 4'hF, 1'b0);
      wait_done("wr0");
      idle();
      chk("wr0_t_aw", t_aw, 1);
      chk("wr0_t_w", t_w, 2);
      chk("wr0_t_b", t_b, 3);
      chk("wr0_t_done", t_done, 4);
      chk("wr0_rdata_unchanged", done_rdata, 32'h0);

      // Instruction fetch with wait states on arready and rvalid
      mode = 2; fix_rdata = 32'h1234_5678; fix_rresp = 2'b00;
      @(posedge clk); #1;
      issue(1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b1);
      wait_done("rd_wait");
      idle();
      chk("rd_wait_arprot", 32'(seen_arprot), 32'h4);
      chk("rd_wait_t_ar", t_ar, 1);
      chk("rd_wait_t_r", t_r, 5);
      chk("rd_wait_t_done", t_done, 8);
      chk("rd_wait_rdata", done_rdata, 32'h1234_5678);
      chk("rd_wait_err", 32'(done_err), 0);

      // Error response, then a clean read
      mode = 1; fix_rdata = 32'hDEAD_BEEF; fix_rresp = 2'b10;
      @(posedge clk); #1;
      issue(1'b0, 32'h0000_0020, 32'h0, 4'h0, 1'b0);
      wait_done("rd_slverr");
      idle();
      fix_rresp = 2'b00; fix_rdata = 32'h0000_00C3;
      chk("rd_slverr_t_done", t_done, 3);
      chk("rd_slverr_err", 32'(done_err), 1);
      chk("rd_slverr_rdata", done_rdata, 32'hDEAD_BEEF);
      @(posedge clk); #1;
      issue(1'b0, 32'h0000_0024, 32'h0, 4'h0, 1'b0);
      wait_done("rd_okay");
      idle();
      chk("rd_okay_err", 32'(done_err), 0);
      chk("rd_okay_rdata", done_rdata, 32'h0000_00C3);

      // Early bvalid and stray awready while waiting on wready
      mode = 3;
      @(posedge clk); #1;
      done_before = done_cnt;
      issue(1'b1, 32'h2000_0008, 32'h0BAD_F00D, 4'h3, 1'b0);
      wait_done("wr_early_b");
      idle();
      chk("wr_early_b_t_w", t_w, 2);
      chk("wr_early_b_t_b", t_b, 6);
      chk("wr_early_b_t_done", t_done, 7);
      repeat (5) @(posedge clk);
      #1;
      chk("wr_early_b_once", done_cnt - done_before, 1);

      // Back-to-back read then write
      mode = 1; fix_rdata = 32'h0A0B_0C0D;
      @(posedge clk); #1;
      issue(1'b0, 32'h0000_0100, 32'h0, 4'h0, 1'b0);
      wait_done("b2b_rd");
      chk("b2b_rd_rdata", done_rdata, 32'h0A0B_0C0D);
      issue(1'b1, 32'h3000_0000, 32'h1122_3344, 4'h8, 1'b0);
      wait_done("b2b_wr");
      idle();
      chk("b2b_wr_t_aw", t_aw, 1);
      chk("b2b_wr_rdata_kept", done_rdata, 32'h0A0B_0C0D);

      // Randomized traffic against a randomized slave
      mode = 0;
      for (int i = 0; i < 150; i++) begin
         wr = 1'($urandom_range(0, 1));
         s  = wr ? 4'($urandom_range(1, 15)) : 4'h0;
         issue(wr, $urandom & 32'hFFFF_FFFC, $urandom, s, 1'($urandom_range(0, 1)));
         wait_done("rand");
         if ($urandom_range(0, 2) != 0) begin
            idle();
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
         end
      end
      idle();
      @(posedge clk); #1;

      // Asynchronous reset while the write is stuck in W
      mode = 3; w_block = 1'b1;
      @(posedge clk); #1;
      issue(1'b1, 32'h4000_0040, 32'hCAFE_BABE, 4'hF, 1'b0);
      n = 0;
      while (!wvalid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("reset_reached_w", 32'(wvalid), 1);
      done_before = done_cnt;
      #2 resetn = 1'b0;
      #1;
      chk_all_zero("reset_mid_w");
      idle();
      outstanding = 1'b0;
      last_read = '0;
      repeat (2) @(posedge clk);
      #2 resetn = 1'b1;
      w_block = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("reset_no_completion", done_cnt - done_before, 0);
      mode = 1; fix_rdata = 32'h5555_AAAA; fix_rresp = 2'b00;
      @(posedge clk); #1;
      issue(1'b0, 32'h0000_0200, 32'h0, 4'h0, 1'b0);
      wait_done("after_reset");
      idle();
      chk("after_reset_t_done", t_done, 3);
      chk("after_reset_rdata", done_rdata, 32'h5555_AAAA);

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
